data_mem_arbiter: RTL and testbench

Two requesters share the single data-memory port through this block: the single-cycle core's load/store path (CPU) and the calculator I/O engine (IO), which moves keypad operands into memory and reads results out for the display. It drives the memory address, write data and write enable. It returns read data to both sides. It stalls the core (PC and register-file write hold) while IO owns the port. It sits between the Execution/Mem stages and the data memory.

---
 rtl/data_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between the core load/store path and the IO engine.
// Latency: CPU access is combinational in the same cycle; IO is granted one cycle after request and IO read data is registered (+1 cycle).
// Backpressure: cpu_stall holds the core while IO owns the port; io_gnt tells IO when its transfer completes at the clock edge.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata/rdata   core load/store path; cpu_stall holds the core
//   io_req/we/addr/wdata          IO engine request; io_gnt marks ownership
//   io_rdata/io_valid             registered IO read data and its one-cycle strobe
//   mem_addr/wdata/we/rdata       data memory port (write on CLK edge, combinational read)

module data_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic [DW-1:0] io_rdata,
    output logic          io_valid,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    // ------------------------------------------------------------------
    // Ownership states
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_CPU_OWN  = 2'd0;
    localparam logic [1:0] ST_IO_OWN   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    // Counters are sized to hold their terminal value inclusively.
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(STARVE_LIMIT);

    logic [1:0]    state_q,     state_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [WW-1:0] wait_cnt_q,  wait_cnt_d;
    logic [DW-1:0] io_rdata_q,  io_rdata_d;
    logic          io_valid_q,  io_valid_d;

    logic          io_own;
    logic          io_xfer;
    logic          io_rd_xfer;
    logic [BW-1:0] burst_inc;
    logic [WW-1:0] wait_inc;

    assign io_own     = (state_q == ST_IO_OWN);
    assign io_xfer    = io_own & io_req;
    assign io_rd_xfer = io_xfer & ~io_we;
    assign burst_inc  = burst_cnt_q + BURST_ONE;
    assign wait_inc   = wait_cnt_q + WAIT_ONE;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_CPU_OWN: begin
                if (io_req) begin
                    // An idle CPU yields at once; a busy CPU yields only after
                    // IO has lost STARVE_LIMIT consecutive cycles to it.
                    if (!cpu_req || (wait_inc == WAIT_MAX)) begin
                        state_d     = ST_IO_OWN;
                        burst_cnt_d = '0;
                        wait_cnt_d  = '0;
                    end else begin
                        wait_cnt_d  = wait_inc;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end

            ST_IO_OWN: begin
                if (!io_req) begin
                    // Release cycle: no transfer, CPU gets the port next cycle.
                    state_d     = ST_CPU_OWN;
                    burst_cnt_d = '0;
                end else if (burst_inc == BURST_MAX) begin
                    state_d     = ST_COOLDOWN;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_inc;
                end
            end

            ST_COOLDOWN: begin
                // One guaranteed unstalled CPU cycle between IO bursts;
                // io_req is deliberately ignored here.
                state_d    = ST_CPU_OWN;
                wait_cnt_d = '0;
            end

            default: begin
                state_d     = ST_CPU_OWN;
                burst_cnt_d = '0;
                wait_cnt_d  = '0;
            end
        endcase
    end

    // IO read data is captured at the edge that completes the read transfer
    // and otherwise holds its last value.
    always_comb begin
        io_valid_d = io_rd_xfer;
        io_rdata_d = io_rd_xfer ? mem_rdata : io_rdata_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_CPU_OWN;
            burst_cnt_q <= '0;
            wait_cnt_q  <= '0;
            io_rdata_q  <= '0;
            io_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            io_rdata_q  <= io_rdata_d;
            io_valid_q  <= io_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Port mux and outputs
    // ------------------------------------------------------------------
    assign mem_addr  = io_own ? io_addr  : cpu_addr;
    assign mem_wdata = io_own ? io_wdata : cpu_wdata;

    // Gated by RST so a transfer in flight when reset hits is never written,
    // even in the window before the state register has settled.
    assign mem_we    = ~RST & (io_own ? (io_req & io_we) : (cpu_req & cpu_we));

    assign io_gnt    = io_own;
    assign cpu_stall = io_own & cpu_req;
    assign cpu_rdata = mem_rdata;
    assign io_rdata  = io_rdata_q;
    assign io_valid  = io_valid_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int MAX_BURST    = 4;
    localparam int STARVE_LIMIT = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        io_req, io_we;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_gnt, io_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(
        .AW(32), .DW(32), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rdata(io_rdata), .io_valid(io_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Data memory attached to the arbiter: write on edge, combinational read.
    logic [31:0] mem [0:255] = '{default: 32'h0};
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge CLK) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    // Reference model: who owns the port, how many transfers IO has made in
    // its current ownership, how many contended cycles IO has lost, whether
    // the CPU is owed its rest cycle, and the expected memory image.
    bit          m_io_owns;
    int          m_xfers;
    int          m_cpu_wins;
    bit          m_rest;
    bit          m_valid;
    logic [31:0] m_rdata;
    logic [31:0] exp_mem [0:255] = '{default: 32'h0};

    int errors = 0;
    int checks = 0;

    logic        last_gnt, last_stall, last_we, last_valid;
    logic [31:0] last_addr, last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_io_owns  = 1'b0;
        m_xfers    = 0;
        m_cpu_wins = 0;
        m_rest     = 1'b0;
        m_valid    = 1'b0;
        m_rdata    = 32'h0;
    endtask

    // One clock cycle: called at the falling edge with inputs already driven.
    task automatic tick();
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        #1;
        e_addr  = m_io_owns ? io_addr  : cpu_addr;
        e_wdata = m_io_owns ? io_wdata : cpu_wdata;
        e_we    = m_io_owns ? (io_req & io_we) : (cpu_req & cpu_we);
        last_gnt = io_gnt; last_stall = cpu_stall; last_we = mem_we;
        last_addr = mem_addr; last_valid = io_valid; last_rdata = io_rdata;
        chk("io_gnt",    32'(io_gnt),    32'(m_io_owns));
        chk("cpu_stall", 32'(cpu_stall), 32'(m_io_owns & cpu_req));
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("mem_addr",  mem_addr,       e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        chk("cpu_rdata", cpu_rdata,      exp_mem[e_addr[9:2]]);
        chk("io_valid",  32'(io_valid),  32'(m_valid));
        chk("io_rdata",  io_rdata,       m_rdata);
        @(posedge CLK);
        if (e_we) exp_mem[e_addr[9:2]] = e_wdata;
        m_valid = 1'b0;
        if (m_io_owns) begin
            if (!io_req) begin
                m_io_owns = 1'b0;
            end else begin
                m_xfers++;
                if (!io_we) begin
                    m_valid = 1'b1;
                    m_rdata = exp_mem[e_addr[9:2]];
                end
                if (m_xfers == MAX_BURST) begin
                    m_io_owns = 1'b0;
                    m_rest    = 1'b1;
                end
            end
        end else if (m_rest) begin
            m_rest     = 1'b0;
            m_cpu_wins = 0;
        end else if (io_req && !cpu_req) begin
            m_io_owns = 1'b1; m_xfers = 0; m_cpu_wins = 0;
        end else if (io_req) begin
            m_cpu_wins++;
            if (m_cpu_wins == STARVE_LIMIT) begin
                m_io_owns = 1'b1; m_xfers = 0; m_cpu_wins = 0;
            end
        end else begin
            m_cpu_wins = 0;
        end
        @(negedge CLK);
    endtask

    initial begin
        int done, first_gnt, fifth, waited, cnt;
        bit got, seen;

        RST = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
        model_reset();

        // Reset values
        @(negedge CLK); #1;
        chk("rst_io_gnt",    32'(io_gnt),    32'h0);
        chk("rst_io_valid",  32'(io_valid),  32'h0);
        chk("rst_io_rdata",  io_rdata,       32'h0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // CPU-only store, then a store that the IO read will fetch later
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        tick();
        chk("cpu_only_we",    32'(last_we),    32'h1);
        chk("cpu_only_addr",  last_addr,       32'h10);
        chk("cpu_only_stall", 32'(last_stall), 32'h0);
        cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
        tick();
        cpu_req = 0; cpu_we = 0;
        tick();
        chk("mem_0x10", mem[4], 32'hDEADBEEF);

        // IO burst of 6 writes with CPU idle
        io_req = 1; io_we = 1; done = 0; first_gnt = -1; fifth = -1;
        for (int t = 0; t < 20 && done < 6; t++) begin
            io_addr  = 32'h20 + 32'(4 * done);
            io_wdata = 32'hB000_0000 + 32'(done);
            tick();
            if (last_gnt) begin
                if (first_gnt < 0) first_gnt = t;
                done++;
                if (done == 5) fifth = t;
            end
        end
        chk("burst_done",  32'(done),      32'd6);
        chk("burst_first", 32'(first_gnt), 32'd1);
        chk("burst_fifth", 32'(fifth),     32'd7);
        io_req = 0;
        tick();
        chk("release_gnt", 32'(last_gnt), 32'h1);
        chk("release_we",  32'(last_we),  32'h0);
        tick();
        chk("mem_0x2c", mem[32'h2C >> 2], 32'hB0000003);
        chk("mem_0x34", mem[32'h34 >> 2], 32'hB0000005);

        // Single IO read of 0x40
        io_req = 1; io_we = 0; io_addr = 32'h40; got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            got = last_gnt;
        end
        chk("read_gnt", 32'(got), 32'h1);
        io_req = 0;
        tick();
        chk("read_valid", 32'(last_valid), 32'h1);
        chk("read_data",  last_rdata,      32'h12345678);
        tick();
        chk("read_valid_drop", 32'(last_valid), 32'h0);

        // Contention: CPU wins STARVE_LIMIT cycles, then IO is forced in
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        io_req = 1; io_we = 1; io_addr = 32'h60; io_wdata = 32'hA5A5A5A5;
        waited = 0; got = 0;
        for (int t = 0; t < 30 && !got; t++) begin
            tick();
            got = last_gnt;
            if (!got) waited++;
        end
        chk("starve_cycles", 32'(waited),     32'(STARVE_LIMIT));
        chk("starve_stall",  32'(last_stall), 32'h1);
        io_addr = 32'h64; io_wdata = 32'h5A5A5A5A;
        tick();
        io_req = 0;
        tick();
        chk("rel2_we",    32'(last_we),    32'h0);
        chk("rel2_stall", 32'(last_stall), 32'h1);
        tick();
        chk("rel2_cpu_gnt",   32'(last_gnt),   32'h0);
        chk("rel2_cpu_stall", 32'(last_stall), 32'h0);
        chk("mem_0x64", mem[32'h64 >> 2], 32'h5A5A5A5A);

        // Burst count restarts from zero after a release
        cpu_req = 0; io_req = 1; io_we = 1; cnt = 0; seen = 0;
        for (int t = 0; t < 15; t++) begin
            io_addr  = 32'h100 + 32'(4 * cnt);
            io_wdata = 32'hC0DE_0000 + 32'(cnt);
            tick();
            if (last_gnt) begin
                cnt++; seen = 1;
            end else if (seen) begin
                break;
            end
        end
        chk("post_release_burst", 32'(cnt), 32'(MAX_BURST));
        io_req = 0;
        tick();

        // Asynchronous reset in the middle of a burst
        io_req = 1; io_we = 0; io_addr = 32'h10; got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            got = last_gnt;
        end
        chk("rst_burst_gnt", 32'(got), 32'h1);
        io_we = 1; io_addr = 32'h80; io_wdata = 32'h77;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1;
        chk("pre_rst_we",    32'(mem_we),   32'h1);
        chk("pre_rst_valid", 32'(io_valid), 32'h1);
        chk("pre_rst_rdata", io_rdata,      32'hDEADBEEF);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_mem_we",    32'(mem_we),    32'h0);
        chk("mid_rst_io_gnt",    32'(io_gnt),    32'h0);
        chk("mid_rst_io_valid",  32'(io_valid),  32'h0);
        chk("mid_rst_io_rdata",  io_rdata,       32'h0);
        chk("mid_rst_cpu_stall", 32'(cpu_stall), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        chk("rst_dropped_write", mem[32'h80 >> 2], 32'h0);
        io_req = 0;
        tick();
        chk("after_rst_stall", 32'(last_stall), 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 32'($urandom_range(0, 255)) << 2;
            cpu_wdata = $urandom;
            io_req    = ($urandom_range(0, 9) < 6);
            io_we     = 1'($urandom_range(0, 1));
            io_addr   = 32'($urandom_range(0, 255)) << 2;
            io_wdata  = $urandom;
            tick();
        end
        cpu_req = 0; io_req = 0;
        tick();
        tick();

        for (int i = 0; i < 256; i++) chk("mem_image", mem[i], exp_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
